// File: rtl/nibbler_fetch_sequencer.sv
// nibbler_fetch_sequencer: PC, fetch/execute phase and jump resolution for the Nibbler CPU
module nibbler_fetch_sequencer #(
    parameter int                     PC_WIDTH     = 12,
    parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                hold,
    input  logic [7:0]          program_byte,
    input  logic                c_flag,
    input  logic                z_flag,
    output logic                phase,
    output logic [PC_WIDTH-1:0] pc,
    output logic [3:0]          instr,
    output logic [3:0]          oprnd,
    output logic [PC_WIDTH-1:0] address_ram,
    output logic                jump_taken
);
    typedef enum logic {FETCH = 1'b0, EXECUTE = 1'b1} state_t;

    state_t              state, state_n;
    logic [PC_WIDTH-1:0] pc_n;
    logic [3:0]          instr_n, oprnd_n;
    logic                is_jump, cond;

    assign phase       = (state == EXECUTE);
    assign address_ram = PC_WIDTH'({oprnd, program_byte});
    assign is_jump     = (instr == 4'b0000) || (instr == 4'b0001) || (instr == 4'b1000) ||
                         (instr == 4'b1001) || (instr == 4'b1100);
    assign cond        = instr[3] ? (instr[2] | (instr[0] ^ z_flag)) : (instr[0] ^ c_flag);
    assign jump_taken  = phase & is_jump & cond;

    // Next state: fetch latches the byte and steps pc; execute resolves jumps; hold freezes everything
    always_comb begin
        state_n = state;
        pc_n    = pc;
        instr_n = instr;
        oprnd_n = oprnd;
        if (!hold) begin
            if (state == FETCH) begin
                state_n            = EXECUTE;
                {instr_n, oprnd_n} = program_byte;
                pc_n               = pc + PC_WIDTH'(1);
            end else begin
                state_n = FETCH;
                pc_n    = jump_taken ? address_ram : is_jump ? pc + PC_WIDTH'(1) : pc;
            end
        end
    end

    // State register; reset abandons any in-flight instruction
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            pc    <= RESET_VECTOR;
            instr <= '0;
            oprnd <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            instr <= instr_n;
            oprnd <= oprnd_n;
        end
    end
endmodule

// File: tb/tb_nibbler_fetch_sequencer.sv
// tb_nibbler_fetch_sequencer: instruction-level reference model checks for the fetch sequencer
module tb_nibbler_fetch_sequencer;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        hold = 1'b0;
    logic [7:0]  program_byte;
    logic        c_flag = 1'b0;
    logic        z_flag = 1'b0;
    logic        phase;
    logic [11:0] pc;
    logic [3:0]  instr, oprnd;
    logic [11:0] address_ram;
    logic        jump_taken;

    logic [7:0]  rom [4096];
    logic [11:0] mpc;
    int          n_cmp = 0;
    int          n_bad = 0;

    assign program_byte = rom[pc];

    nibbler_fetch_sequencer dut (
        .clock(clock), .reset(reset), .hold(hold), .program_byte(program_byte),
        .c_flag(c_flag), .z_flag(z_flag), .phase(phase), .pc(pc), .instr(instr),
        .oprnd(oprnd), .address_ram(address_ram), .jump_taken(jump_taken)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // One whole instruction against the model: fetch, optional held cycles in execute, execute
    task automatic run_instr(input bit c, input bit z, input int nh);
        logic [7:0]  b, a;
        logic [3:0]  op;
        logic [11:0] nxt;
        bit          jmp, tk;
        b   = rom[mpc];
        a   = rom[mpc + 12'd1];
        op  = b[7:4];
        jmp = (op == 4'h0) || (op == 4'h1) || (op == 4'h8) || (op == 4'h9) || (op == 4'hC);
        tk  = (op == 4'h0 && c) || (op == 4'h1 && !c) || (op == 4'h8 && z) ||
              (op == 4'h9 && !z) || (op == 4'hC);
        nxt = tk ? {b[3:0], a} : jmp ? mpc + 12'd2 : mpc + 12'd1;
        c_flag = c;
        z_flag = z;
        n_cmp++;
        if (pc !== mpc || phase !== 1'b0 || jump_taken !== 1'b0) begin
            n_bad++;
            $display("FAIL pre_fetch: pc=%h phase=%b jt=%b, want pc=%h phase=0 jt=0", pc, phase, jump_taken, mpc);
        end
        tick();
        n_cmp++;
        if ({instr, oprnd} !== b || pc !== mpc + 12'd1 || phase !== 1'b1) begin
            n_bad++;
            $display("FAIL fetch_edge: instr/oprnd=%h pc=%h phase=%b, want %h pc=%h phase=1", {instr, oprnd}, pc, phase, b, mpc + 12'd1);
        end
        n_cmp++;
        if (jump_taken !== tk) begin
            n_bad++;
            $display("FAIL jump_taken: got %b want %b (op=%h c=%b z=%b)", jump_taken, tk, op, c, z);
        end
        if (jmp) begin
            n_cmp++;
            if (address_ram !== {b[3:0], a}) begin
                n_bad++;
                $display("FAIL address_ram: got %h want %h", address_ram, {b[3:0], a});
            end
        end
        hold = 1'b1;
        for (int i = 0; i < nh; i++) begin
            tick();
            n_cmp++;
            if (pc !== mpc + 12'd1 || phase !== 1'b1 || {instr, oprnd} !== b) begin
                n_bad++;
                $display("FAIL hold: pc=%h phase=%b instr/oprnd=%h, want pc=%h phase=1 %h", pc, phase, {instr, oprnd}, mpc + 12'd1, b);
            end
        end
        hold = 1'b0;
        tick();
        n_cmp++;
        if (pc !== nxt || phase !== 1'b0 || {instr, oprnd} !== b) begin
            n_bad++;
            $display("FAIL exec_edge: pc=%h phase=%b instr/oprnd=%h, want pc=%h phase=0 %h", pc, phase, {instr, oprnd}, nxt, b);
        end
        mpc = nxt;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if (pc !== 12'h000 || phase !== 1'b0 || instr !== 4'h0 || oprnd !== 4'h0 || jump_taken !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: pc=%h phase=%b instr=%h oprnd=%h jt=%b, want all zero", pc, phase, instr, oprnd, jump_taken);
        end
        @(negedge clock);
        reset = 1'b0;
        mpc = 12'h000;
    endtask

    task automatic test_fetch();
        run_instr(0, 0, 0);
        run_instr(0, 0, 0);
    endtask

    task automatic test_jmp();
        run_instr(0, 0, 0);
        run_instr(0, 0, 0);
    endtask

    task automatic test_jc();
        run_instr(0, 0, 0);
        run_instr(1, 0, 0);
    endtask

    task automatic test_jz();
        run_instr(0, 1, 0);
        run_instr(0, 1, 0);
    endtask

    task automatic test_wrap();
        run_instr(0, 0, 0);
        run_instr(1, 0, 0);
        n_cmp++;
        if (pc !== 12'h000) begin
            n_bad++;
            $display("FAIL wrap: pc=%h want 000", pc);
        end
    endtask

    task automatic test_hold();
        run_instr(0, 0, 0);
        run_instr(0, 0, 3);
    endtask

    task automatic test_async_reset();
        tick();
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (pc !== 12'h000 || phase !== 1'b0 || instr !== 4'h0 || oprnd !== 4'h0) begin
            n_bad++;
            $display("FAIL async_reset: pc=%h phase=%b instr=%h oprnd=%h, want 000/0/0/0", pc, phase, instr, oprnd);
        end
        @(negedge clock);
        reset = 1'b0;
        mpc = 12'h000;
    endtask

    task automatic test_random();
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        mpc = 12'h000;
        for (int i = 0; i < 300; i++)
            run_instr(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'h20;
        rom[12'h000] = 8'h49; rom[12'h001] = 8'hD0;
        rom[12'h002] = 8'hC0; rom[12'h003] = 8'h2E;
        rom[12'h02E] = 8'hC0; rom[12'h02F] = 8'h34;
        rom[12'h034] = 8'h00; rom[12'h035] = 8'h45;
        rom[12'h036] = 8'h00; rom[12'h037] = 8'h45;
        rom[12'h045] = 8'h90; rom[12'h046] = 8'h50;
        rom[12'h047] = 8'h80; rom[12'h048] = 8'h50;
        rom[12'h050] = 8'hCF; rom[12'h051] = 8'hFE;
        rom[12'hFFE] = 8'h10; rom[12'hFFF] = 8'h00;
        test_reset();
        test_fetch();
        test_jmp();
        test_jc();
        test_jz();
        test_wrap();
        test_hold();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/nibbler_fetch_sequencer.md
Name: nibbler_fetch_sequencer

Overview:
- Fetch/sequencing stage of the 4-bit Nibbler processor. Sits directly upstream of the decode/ALU/accumulator datapath.
- Owns the 12-bit program counter and the phase toggle, and drives the program ROM address.
- Latches each fetched program byte into instr/oprnd for the decoder.
- Resolves all jump instructions (JC, JNC, JZ, JNZ, JMP) using the flags that the ALU stage has already registered.

Parameters:
- PC_WIDTH, 12, program counter / ROM address width.
- RESET_VECTOR, 12'h000, PC value after reset.

Ports:
- clock  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- hold  input  1  when 1, freeze all state (single-step/debug)
- program_byte  input  8  ROM data at address pc (combinational ROM)
- c_flag  input  1  registered carry flag from ALU stage
- z_flag  input  1  registered zero flag from ALU stage
- phase  output  1  0 = fetch, 1 = execute
- pc  output  PC_WIDTH  current program counter / ROM address
- instr  output  4  fetched opcode, program_byte[7:4]
- oprnd  output  4  fetched operand, program_byte[3:0]
- address_ram  output  PC_WIDTH  {oprnd, program_byte}; RAM address for LD/ST/ADDM/NANDM/CMPM and jump target
- jump_taken  output  1  combinational; 1 during execute phase when the current jump condition holds

Behaviour:
- Reset: asynchronous, active-high.
  - While reset=1: phase=0, pc=RESET_VECTOR, instr=0, oprnd=0. jump_taken=0 follows.
  - A reset asserted mid-instruction abandons that instruction; there is no partial PC update.
- Each instruction takes exactly 2 clock cycles: a fetch cycle (phase=0) followed by an execute cycle (phase=1). Phase toggles on every rising edge when hold=0.
- Fetch edge (phase=0 at the edge, hold=0):
  - {instr, oprnd} <= program_byte.
  - pc <= pc+1.
  - phase <= 1.
- Execute edge (phase=1 at the edge, hold=0):
  - instr and oprnd are held.
  - phase <= 0.
  - PC update depends on the opcode:
    - Non-jump opcodes (0010–0111, 1010, 1011, 1101, 1110, 1111): pc unchanged. The next fetch reads the byte after the instruction.
    - Jump opcodes are 2 bytes. During execute, program_byte is the low address byte at pc.
      - Taken: pc <= {oprnd, program_byte}.
      - Not taken: pc <= pc+1, skipping the address byte.
- Jump conditions (use c_flag and z_flag values sampled at the execute edge):
  - 0000 JC: taken if c_flag=1.
  - 0001 JNC: taken if c_flag=0.
  - 1000 JZ: taken if z_flag=1.
  - 1001 JNZ: taken if z_flag=0.
  - 1100 JMP: always taken.
- jump_taken = phase & jump opcode & condition. It is 0 in the fetch phase.
- address_ram is combinational: {oprnd, program_byte}. It is valid during execute.
- Arithmetic: pc increments modulo 2^PC_WIDTH, so 0xFFF+1 = 0x000. A not-taken jump whose address byte sits at 0xFFF wraps to 0x000.
- Hold:
  - hold=1 at an edge: phase, pc, instr and oprnd are all unchanged.
  - Combinational outputs keep tracking their inputs.
  - Releasing hold resumes in the same phase.
  - Reset overrides hold.
- Flags are never modified by this block.

Test Plan:
- Reset/fetch: ROM[000]=0x49 (LIT 9), ROM[001]=0xD0; pulse reset at t=1 -> pc=000, phase=0. After edge 1: instr=4, oprnd=9, pc=001, phase=1. After edge 2: phase=0, pc=001.
- JMP: ROM[02E]=0xC0, ROM[02F]=0x34 -> at execute, jump_taken=1 and address_ram=034. After the execute edge, pc=034.
- JC not taken / taken: c_flag=0, ROM[034]=0x00, ROM[035]=0x45 -> pc=036 after the instruction. Repeat with c_flag=1 -> pc=045.
- JZ/JNZ: z_flag=1 with JNZ 0x050 -> not taken, pc advances by 2. Same flags with JZ 0x050 -> pc=050.
- Wrap: force pc to FFE with ROM[FFE]=0x10 (JNC), ROM[FFF]=0x00, c_flag=1 -> pc=000 afterwards.
- Hold/reset mid-op:
  - hold=1 for 3 edges during execute -> pc, phase and instr stable. On release, execute completes normally.
  - Reset asserted asynchronously mid-cycle -> pc=000 and phase=0 immediately, without waiting for a clock edge.
